// File: rtl/pe_pkg.sv
// pe_pkg: shared constants and reader state encoding for the PE result register bank.
package pe_pkg;
    localparam int PE_DATA_WIDTH = 32;
    localparam int PE_NUM        = 8;
    typedef enum logic [1:0] {IDLE, FETCH, LATCH, SEND} reader_state_t;
endpackage

// File: rtl/pe_result_reader.sv
// pe_result_reader: drains NUM_PE result registers through a 1-cycle read port onto a valid/ready stream.
// Define PE_READER_CLR_EN to add clr_en, zeroing each register the cycle after its word is accepted.
module pe_result_reader
    import pe_pkg::*;
#(
    parameter int  WIDTH  = PE_DATA_WIDTH,
    parameter int  NUM_PE = PE_NUM,
    localparam int IDX_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_idx,
    input  logic [WIDTH-1:0] rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             done
`ifdef PE_READER_CLR_EN
    ,
    output logic             clr_en
`endif
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

    reader_state_t    r_state;
    logic             r_busy, r_rd_en, r_out_valid, r_out_last, r_done;
    logic [IDX_W-1:0] r_rd_idx;
    logic [WIDTH-1:0] r_out_data;
    logic             w_last;

    assign w_last    = r_rd_idx == LAST_IDX;
    assign busy      = r_busy;
    assign rd_en     = r_rd_en;
    assign rd_idx    = r_rd_idx;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign done      = r_done;

`ifdef PE_READER_CLR_EN
    logic r_clr_en;
    assign clr_en = r_clr_en;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_idx    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
`ifdef PE_READER_CLR_EN
            r_clr_en    <= 1'b0;
`endif
        end else begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
`ifdef PE_READER_CLR_EN
            r_clr_en <= 1'b0;
`endif
            case (r_state)
                IDLE: if (start) begin
                    r_rd_idx <= '0;
                    r_rd_en  <= 1'b1;
                    r_busy   <= 1'b1;
                    r_state  <= FETCH;
                end
                FETCH: begin
`ifdef PE_READER_CLR_EN
                    // index advances only after the clear cycle so clr_en sees the accepted index
                    if (r_clr_en) begin
                        r_rd_idx <= r_rd_idx + IDX_W'(1);
                        r_rd_en  <= 1'b1;
                    end else
`endif
                    r_state <= LATCH;
                end
                LATCH: begin
                    r_out_data  <= rd_data;
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_last;
                    r_state     <= SEND;
                end
                SEND: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
`ifdef PE_READER_CLR_EN
                    r_clr_en    <= 1'b1;
`endif
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_state <= FETCH;
`ifndef PE_READER_CLR_EN
                        r_rd_idx <= r_rd_idx + IDX_W'(1);
                        r_rd_en  <= 1'b1;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/pe_result_reader.md
Name: pe_result_reader

Overview:
- Read-side drain engine for the PE result register bank.
- On `start`, reads each of `NUM_PE` 32-bit PE result registers in index order through a 1-cycle-latency read port.
- Presents each word on a valid/ready output stream to the host/output buffer, marks the final word with `out_last`, and pulses `done` when the drain completes.

Parameters:
- WIDTH, 32, data width of each PE result register and of the output stream.
- NUM_PE, 8, number of registers drained per `start`; legal range 1..256.
- IDX_W, localparam = max(1, $clog2(NUM_PE)), width of the read index.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset of all state.
- start  in  1  1-cycle pulse; begins a drain; honoured only in IDLE.
- busy  out  1  high in any state other than IDLE.
- rd_en  out  1  read strobe to the register bank.
- rd_idx  out  IDX_W  index of the register being read or sent.
- rd_data  in  WIDTH  bank read data, valid exactly 1 cycle after `rd_en`.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word when valid and ready are both high.
- out_data  out  WIDTH  output word.
- out_last  out  1  high with `out_valid` on the word where rd_idx == NUM_PE-1.
- done  out  1  1-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async assert): state=IDLE; busy, rd_en, out_valid, out_last, done = 0; rd_idx=0; out_data=0.
  - Reset mid-drain aborts silently: no `done`, no further reads.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: on `start`, set rd_idx=0 and go to FETCH. Otherwise stay.
  - FETCH: rd_en=1 for exactly this cycle. Next state is LATCH.
  - LATCH: capture out_data<=rd_data. Set out_valid=1 and out_last=(rd_idx==NUM_PE-1). Next state is SEND.
  - SEND: hold out_valid, out_data and out_last stable while !out_ready. On accept:
    - if last: clear out_valid and out_last, pulse done, go to IDLE;
    - else: rd_idx+1, clear out_valid, go to FETCH.
- Timing:
  - Minimum 3 cycles per word.
  - First `out_valid` appears 3 cycles after the `start` edge.
  - `done` is high during the first IDLE cycle after the final accept.
- `start` while busy is ignored. A `start` coincident with `done` is accepted as a new drain.
- `out_ready` outside SEND has no effect.
- rd_idx never exceeds NUM_PE-1; no wrap occurs within a drain. rd_idx holds its last value in IDLE until the next start.
- NUM_PE=1: a single word with out_last=1.
- out_data retains the last latched word after accept; it is only meaningful while out_valid=1.

Optional Feature:
- Macro: PE_READER_CLR_EN (read-and-clear).
- Defined:
  - Adds output port `clr_en` (1 bit).
  - `clr_en` is registered high for exactly 1 cycle, the cycle after each accept, with rd_idx still equal to the accepted word's index.
  - clr_en=0 on reset and in all other cycles.
  - The bank zeroes that register in that cycle.
- Undefined: the port is absent; bank contents are unchanged by a drain.

Decomposition:
- Shared package `pe_pkg`:
  - PE_DATA_WIDTH=32, PE_NUM=8;
  - reader state enum typedef (IDLE, FETCH, LATCH, SEND; 2-bit encoding).
- Single flat module; no sub-module is natural. The index counter and FSM are tightly coupled.

Test Plan:
- NUM_PE=8, bank[i]=32'h1000_0000+i, out_ready tied 1, one start pulse:
  - 8 words 0x10000000..0x10000007 in order, one per 3 cycles;
  - out_last only on 0x10000007;
  - done one cycle later.
- Backpressure: out_ready=0 for 5 cycles on word 3 → out_valid, out_data=0x10000003 and rd_idx=3 held stable; no rd_en pulses; resumes correctly.
- start pulsed while busy (word 2 in SEND) → ignored; exactly 8 words and one done.
- Back-to-back: start asserted in the done cycle → second drain begins, first word 3 cycles later, identical sequence.
- Async reset asserted mid-SEND of word 5 → all outputs 0 immediately (before next edge), no done. A subsequent start drains from index 0.
- PE_READER_CLR_EN defined:
  - clr_en pulses 8 times, each with rd_idx 0..7;
  - a second drain returns all 0x00000000.
